// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings and sizing helpers for seq_alu
`timescale 1ns/1ps
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative shift-add multiplier and restoring divider
`timescale 1ns/1ps
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int CW = cnt_width(WIDTH);

  // acc holds the product for MUL, {remainder, dividend/quotient} for DIV.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    trial    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff     = trial - {1'b0, mcand_q[WIDTH-1:0]};
    if (start_i) begin
      is_div_d = is_div_i;
      cnt_d    = CW'(WIDTH);
      if (is_div_i) begin
        acc_d   = {{WIDTH{1'b0}}, a_i};
        mcand_d = {{WIDTH{1'b0}}, b_i};
      end else begin
        acc_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, a_i};
        mplier_d = b_i;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      if (is_div_q) begin
        // Remainder stays below the divisor, so a non-negative diff fits WIDTH bits.
        if (!diff[WIDTH]) begin
          acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
    end
  end

  assign done_o = (cnt_q == CW'(1)) && !start_i;
  assign lo_o   = acc_d[WIDTH-1:0];
  assign hi_o   = acc_d[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - clocked ADD/SUB/MUL/DIV unit with valid/ready handshakes
`timescale 1ns/1ps
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] f_hi,
  output logic             carry,
  output logic             zero,
  output logic             div0
);

  state_e           state_q;
  logic             in_ready_q, out_valid_q;
  logic [WIDTH-1:0] f_q, f_hi_q;
  logic             carry_q, zero_q, div0_q;

  logic             accept;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_lo, md_hi;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] dif;

  assign accept   = in_valid && in_ready_q;
  assign md_start = accept && ((op == OP_MUL) || ((op == OP_DIV) && (b != '0)));
  assign sum      = {1'b0, a} + {1'b0, b};
  assign dif      = a - b;

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (md_start),
    .is_div_i (op == OP_DIV),
    .a_i      (a),
    .b_i      (b),
    .done_o   (md_done),
    .lo_o     (md_lo),
    .hi_o     (md_hi)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      f_q         <= '0;
      f_hi_q      <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            f_hi_q <= '0;
            div0_q <= 1'b0;
            unique case (op)
              OP_ADD: begin
                f_q         <= sum[WIDTH-1:0];
                carry_q     <= sum[WIDTH];
                zero_q      <= (sum[WIDTH-1:0] == '0);
                state_q     <= S_DONE;
                out_valid_q <= 1'b1;
              end
              OP_SUB: begin
                f_q         <= dif;
                carry_q     <= (a < b);
                zero_q      <= (dif == '0);
                state_q     <= S_DONE;
                out_valid_q <= 1'b1;
              end
              OP_MUL: begin
                state_q <= S_MUL;
              end
              default: begin
                if (b == '0) begin
                  f_q         <= '1;
                  f_hi_q      <= a;
                  carry_q     <= 1'b0;
                  zero_q      <= 1'b0;
                  div0_q      <= 1'b1;
                  state_q     <= S_DONE;
                  out_valid_q <= 1'b1;
                end else begin
                  state_q <= S_DIV;
                end
              end
            endcase
            in_ready_q <= 1'b0;
          end
        end
        S_MUL, S_DIV: begin
          // Capture the final iteration's next-state so results land with DONE.
          if (md_done) begin
            f_q         <= md_lo;
            f_hi_q      <= md_hi;
            carry_q     <= (state_q == S_MUL) && (md_hi != '0);
            zero_q      <= (md_lo == '0);
            div0_q      <= 1'b0;
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign f         = f_q;
  assign f_hi      = f_hi_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign div0      = div0_q;

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, clocked successor to the 2-bit-opcode combinational ALU. Supports ADD, SUB, MUL and DIV on WIDTH-bit unsigned operands. ADD and SUB finish in one cycle; MUL and DIV run as iterative shift-add and restoring-divide sequences over WIDTH cycles. Operands enter through a valid/ready input handshake; results leave through a valid/ready output handshake with status flags, so the block can sit between a register-file read stage and a write-back stage.

## Interface
- WIDTH, 8: operand and result width; must be ≥ 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A (dividend), unsigned.
- b  in  WIDTH  operand B (divisor), unsigned.
- op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- f  out  WIDTH  ADD/SUB result, product low half, or quotient.
- f_hi  out  WIDTH  product high half or remainder; 0 for ADD/SUB.
- carry  out  1  carry-out (ADD), borrow a<b (SUB), f_hi≠0 (MUL); 0 for DIV.
- zero  out  1  f == 0.
- div0  out  1  DIV with b == 0.

## Operation
- States: IDLE, MUL, DIV, DONE.
- in_ready = 1 only in IDLE. An operation is accepted on the rising edge where in_valid && in_ready; a, b and op are registered at that edge.
- IDLE, ADD/SUB accepted: compute into the result registers, go to DONE.
- IDLE, DIV with b==0 accepted: f = all ones, f_hi = a, div0 = 1, go to DONE.
- IDLE, MUL accepted: clear the 2·WIDTH accumulator, load the iteration counter with WIDTH, go to MUL. Each cycle: add the shifted multiplicand if the current multiplier LSB is 1, shift, decrement. When the counter reaches 0, go to DONE.
- IDLE, DIV (b≠0) accepted: restoring division, one quotient bit per cycle, MSB first, WIDTH cycles. When done, go to DONE.
- DONE: out_valid = 1. f, f_hi and all flags stay stable until out_valid && out_ready, then go to IDLE.
- Arithmetic: ADD and SUB wrap modulo 2^WIDTH; SUB borrow = (a < b). MUL gives the exact 2·WIDTH product as {f_hi, f}. DIV: a = f·b + f_hi, with f_hi < b.
- op changes while busy are ignored; the operands latched at acceptance are used.
- Reset (rst_n sampled low): state = IDLE, in_ready = 1 on the next cycle, out_valid = 0, and f, f_hi, carry, zero, div0 all = 0. Any in-flight operation is discarded with no output.

## Timing
- Acceptance edge = cycle N.
- ADD, SUB and DIV-by-zero: out_valid high from cycle N+1.
- MUL and DIV: out_valid high from cycle N+WIDTH+1 (N+9 at WIDTH = 8).
- Output handshake at cycle M: IDLE at M+1, so in_ready is high at M+1. There is no same-cycle accept and complete.
- Peak throughput: one ADD per 2 cycles; one MUL or DIV per WIDTH+2 cycles.
- All outputs come from registers; there are no combinational paths from inputs to outputs.

## Structure
- Package alu_pkg holds:
  - op encodings OP_ADD, OP_SUB, OP_MUL, OP_DIV;
  - the state enum;
  - the counter width as $clog2(WIDTH+1).
- Sub-module alu_muldiv holds the shared iterative datapath: accumulator/remainder register, shift logic, counter, and a done pulse. seq_alu owns the FSM, the handshakes, ADD/SUB and flag generation.

## Test plan
All scenarios use WIDTH = 8.
- ADD 15+10 → f=25, carry=0, zero=0, out_valid at N+1. ADD 200+100 → f=44, carry=1.
- SUB 25−5 → f=20, carry=0. SUB 5−25 → f=236, carry=1. SUB 7−7 → f=0, zero=1.
- MUL 3×4 → f=12, f_hi=0, carry=0, out_valid exactly at N+9. MUL 200×3 → f=88, f_hi=2, carry=1.
- DIV 20/4 → f=5, f_hi=0. DIV 23/4 → f=5, f_hi=3, at N+9. DIV 20/0 → f=255, f_hi=20, div0=1, at N+1.
- Backpressure: hold out_ready=0 for 3 cycles after a MUL completes → f, f_hi and flags stable; in_ready=0; in_valid pulses during that time are not accepted.
- Reset mid-MUL: drive rst_n low at cycle N+4 → next cycle out_valid=0, all outputs 0, in_ready=1. A following ADD 1+1 returns f=2.
